// File: rtl/water_dispenser_pkg.sv
// Shared constants, state encoding and saturating volume arithmetic for the water dispenser.
package water_dispenser_pkg;

    localparam int MAXIMUM_VOLUME_IN_ML = 9999;
    localparam int VOLUME_BIT_COUNT     = 14;
    localparam int CLOCK_PERIOD_IN_NS   = 20;

    typedef logic [VOLUME_BIT_COUNT-1:0] volume_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRIME    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CLOSE    = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    function automatic volume_t sat_add(input volume_t a, input int unsigned inc);
        int unsigned s;
        s = 32'(a) + inc;
        if (s > MAXIMUM_VOLUME_IN_ML)
            return volume_t'(MAXIMUM_VOLUME_IN_ML);
        return volume_t'(s);
    endfunction

endpackage

// File: rtl/flow_pulse_detector.sv
// Two-flop synchronizer and rising-edge detector for the raw flow-meter input.
// Edge first sampled at clock k gives o_pulse high during the cycle after k+1.
module flow_pulse_detector (
    input  logic clock,
    input  logic reset,
    input  logic i_flow_pulse,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_flow_pulse;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/water_valve_sequencer.sv
// Pump/valve sequencer: prime, dispense to a counted volume, close delay, no-flow fault.
// All outputs are registered and change on the edge that enters each state.
module water_valve_sequencer
    import water_dispenser_pkg::*;
#(
    parameter int ML_PER_PULSE           = 10,
    parameter int PRIME_CYCLES           = 8,
    parameter int CLOSE_DELAY_CYCLES     = 4,
    parameter int NO_FLOW_TIMEOUT_CYCLES = 1000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        cancel,
    input  logic [VOLUME_BIT_COUNT-1:0] requested_ml,
    input  logic                        flow_pulse,
    output logic                        pump_on,
    output logic                        valve_open,
    output logic                        busy,
    output logic                        done,
    output logic                        fault,
    output logic [VOLUME_BIT_COUNT-1:0] dispensed_ml
);

    localparam int TIMER_MAX_A = (PRIME_CYCLES > CLOSE_DELAY_CYCLES) ? PRIME_CYCLES : CLOSE_DELAY_CYCLES;
    localparam int TIMER_MAX   = (TIMER_MAX_A > NO_FLOW_TIMEOUT_CYCLES) ? TIMER_MAX_A : NO_FLOW_TIMEOUT_CYCLES;
    localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

    state_t             r_state, w_state_nxt;
    logic [TIMER_W-1:0] r_timer, w_timer_nxt;
    volume_t            r_target, w_target_nxt;
    volume_t            r_dispensed, w_dispensed_nxt;
    logic               r_abort, w_abort_nxt;
    logic               w_done_nxt;
    logic               w_pulse;
    logic               w_start_ok;
    volume_t            w_volume_pulse;

    logic r_pump_on, r_valve_open, r_busy, r_done, r_fault;

    flow_pulse_detector u_detector (
        .clock        (clock),
        .reset        (reset),
        .i_flow_pulse (flow_pulse),
        .o_pulse      (w_pulse)
    );

    assign w_volume_pulse = sat_add(r_dispensed, ML_PER_PULSE);
    assign w_start_ok     = start && (requested_ml != '0) &&
                            (requested_ml <= volume_t'(MAXIMUM_VOLUME_IN_ML));

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_target_nxt    = r_target;
        w_dispensed_nxt = r_dispensed;
        w_abort_nxt     = r_abort;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cancel) begin
                    w_dispensed_nxt = '0;
                end else if (w_start_ok) begin
                    w_target_nxt    = requested_ml;
                    w_dispensed_nxt = '0;
                    w_abort_nxt     = 1'b0;
                    w_timer_nxt     = '0;
                    w_state_nxt     = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (w_pulse) w_dispensed_nxt = w_volume_pulse;
                if (cancel) begin
                    w_abort_nxt = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_CLOSE;
                end else if (r_timer == TIMER_W'(PRIME_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_DISPENSE;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            ST_DISPENSE: begin
                // In this state the timer is the no-flow counter.
                if (w_pulse) begin
                    w_dispensed_nxt = w_volume_pulse;
                    w_timer_nxt     = '0;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
                if (cancel) begin
                    w_abort_nxt = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_CLOSE;
                end else if (w_pulse && (w_volume_pulse >= r_target)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_CLOSE;
                end else if (!w_pulse && (r_timer == TIMER_W'(NO_FLOW_TIMEOUT_CYCLES - 1))) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_CLOSE: begin
                if (w_pulse) w_dispensed_nxt = w_volume_pulse;
                if (r_timer == TIMER_W'(CLOSE_DELAY_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    w_done_nxt  = ~r_abort;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            ST_FAULT: begin
                if (cancel) begin
                    w_dispensed_nxt = '0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_target     <= '0;
            r_dispensed  <= '0;
            r_abort      <= 1'b0;
            r_pump_on    <= 1'b0;
            r_valve_open <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_target     <= w_target_nxt;
            r_dispensed  <= w_dispensed_nxt;
            r_abort      <= w_abort_nxt;
            r_pump_on    <= (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_DISPENSE);
            r_valve_open <= (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CLOSE);
            r_busy       <= (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_DISPENSE) ||
                            (w_state_nxt == ST_CLOSE);
            r_done       <= w_done_nxt;
            r_fault      <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pump_on      = r_pump_on;
    assign valve_open   = r_valve_open;
    assign busy         = r_busy;
    assign done         = r_done;
    assign fault        = r_fault;
    assign dispensed_ml = r_dispensed;

endmodule

// File: tb/tb_water_valve_sequencer.sv
// Bench for water_valve_sequencer: job table with end-of-job scoreboard, plus timing,
// fault, cancel-priority and asynchronous-reset sequences.
module tb_water_valve_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [13:0] requested_ml;
    logic        flow_pulse;
    logic        pump_on;
    logic        valve_open;
    logic        busy;
    logic        done;
    logic        fault;
    logic [13:0] dispensed_ml;

    water_valve_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .cancel       (cancel),
        .requested_ml (requested_ml),
        .flow_pulse   (flow_pulse),
        .pump_on      (pump_on),
        .valve_open   (valve_open),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .dispensed_ml (dispensed_ml)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct {
        int req;
        int pulses;
        int do_cancel;
        int valid;
        int exp_disp;
        int exp_done;
    } vec_t;

    typedef struct {
        int disp;
        int done;
        int fault;
    } exp_t;

    exp_t exp_q[$];
    vec_t vt[8];

    int n_cmp = 0;
    int n_bad = 0;
    int prime_cnt = 0;
    int close_cnt = 0;
    int done_cnt = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        flow_pulse = 1'b1;
        tick();
        tick();
        flow_pulse = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_valve();
        for (int n = 0; n < 30 && !valve_open; n++) tick();
        chk("valve_wait", valve_open, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && busy; n++) tick();
        chk("idle_wait", busy, 0);
    endtask

    // End-of-job monitor: every busy fall must match the oldest expected record.
    always @(negedge clock) begin
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_job_end", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("end_disp", int'(dispensed_ml), e.disp);
                chk("end_done", int'(done), e.done);
                chk("end_fault", int'(fault), e.fault);
            end
        end
        prev_busy = busy;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (pump_on && !valve_open) prime_cnt++;
            if (!pump_on && valve_open) close_cnt++;
            if (done) done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d expected 0", exp_q.size());
        $fatal(1);
    end

    initial begin
        int last_disp;
        int d0;
        int seen;
        int n;

        vt[0] = '{30,    3, 0, 1, 30, 1};
        vt[1] = '{25,    3, 0, 1, 30, 1};
        vt[2] = '{50,    2, 1, 1, 20, 0};
        vt[3] = '{0,     0, 0, 0, 0,  0};
        vt[4] = '{10000, 0, 0, 0, 0,  0};
        vt[5] = '{9999,  0, 1, 1, 0,  0};
        vt[6] = '{10,    1, 0, 1, 10, 1};
        vt[7] = '{1,     1, 0, 1, 10, 1};

        reset = 1'b1;
        start = 1'b0;
        cancel = 1'b0;
        requested_ml = '0;
        flow_pulse = 1'b0;
        repeat (3) tick();
        chk("rst_pump", pump_on, 0);
        chk("rst_valve", valve_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_disp", dispensed_ml, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Pump comes on the cycle after start, valve stays closed while priming.
        requested_ml = 14'd30;
        exp_q.push_back('{30, 1, 0});
        prime_cnt = 0;
        close_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t_pump_next", pump_on, 1);
        chk("t_valve_prime", valve_open, 0);
        chk("t_busy", busy, 1);
        wait_valve();
        repeat (3) pulse();
        wait_idle();
        tick();
        chk("t_prime_len", prime_cnt, 8);
        chk("t_close_len", close_cnt, 4);
        repeat (5) tick();
        chk("t_disp_hold", dispensed_ml, 30);
        last_disp = 30;

        for (int i = 0; i < 8; i++) begin
            requested_ml = vt[i].req[13:0];
            prime_cnt = 0;
            close_cnt = 0;
            d0 = done_cnt;
            if (vt[i].valid != 0) exp_q.push_back('{vt[i].exp_disp, vt[i].exp_done, 0});
            start = 1'b1;
            tick();
            start = 1'b0;
            if (vt[i].valid == 0) begin
                seen = 0;
                repeat (4) begin
                    if (busy || pump_on) seen = 1;
                    tick();
                end
                chk("ign_busy_or_pump", seen, 0);
                chk("ign_disp_hold", dispensed_ml, last_disp);
            end else begin
                wait_valve();
                for (int p = 0; p < vt[i].pulses; p++) pulse();
                if (vt[i].do_cancel != 0) begin
                    cancel = 1'b1;
                    tick();
                    cancel = 1'b0;
                end
                wait_idle();
                tick();
                tick();
                chk("vec_prime_len", prime_cnt, 8);
                chk("vec_close_len", close_cnt, 4);
                chk("vec_done_count", done_cnt - d0, vt[i].exp_done);
                last_disp = vt[i].exp_disp;
            end
        end

        // Cancel beats start in IDLE and clears the held volume.
        requested_ml = 14'd30;
        start = 1'b1;
        cancel = 1'b1;
        tick();
        start = 1'b0;
        cancel = 1'b0;
        tick();
        chk("cs_busy", busy, 0);
        chk("cs_disp", dispensed_ml, 0);

        // Synchronizer latency: edge sampled at k counts at k+2.
        requested_ml = 14'd100;
        exp_q.push_back('{10, 0, 0});
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valve();
        flow_pulse = 1'b1;
        tick();
        chk("lat_k", dispensed_ml, 0);
        tick();
        chk("lat_k1", dispensed_ml, 0);
        tick();
        chk("lat_k2", dispensed_ml, 10);
        flow_pulse = 1'b0;
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_idle();
        tick();

        // No-flow fault after exactly 1000 dispense cycles.
        requested_ml = 14'd100;
        exp_q.push_back('{0, 0, 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valve();
        n = 0;
        while (!fault && n < 1100) begin
            tick();
            n++;
        end
        chk("nof_fault", fault, 1);
        chk("nof_cycles", n, 1000);
        chk("nof_pump", pump_on, 0);
        chk("nof_valve", valve_open, 0);
        chk("nof_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("flt_start_ign", fault, 1);
        chk("flt_start_busy", busy, 0);
        pulse();
        chk("flt_pulse_ign", dispensed_ml, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        chk("flt_clear", fault, 0);
        chk("flt_idle_busy", busy, 0);
        chk("flt_disp", dispensed_ml, 0);

        // Asynchronous reset in the middle of a dispense cycle.
        requested_ml = 14'd100;
        exp_q.push_back('{0, 0, 0});
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valve();
        repeat (3) tick();
        d0 = done_cnt;
        #5;
        reset = 1'b1;
        #1;
        chk("arst_pump", pump_on, 0);
        chk("arst_valve", valve_open, 0);
        chk("arst_busy", busy, 0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        repeat (20) tick();
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_idle", busy, 0);

        chk("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
